// File: rtl/tiny45_pkg.sv
// Shared definitions for the tiny45 shifter: ALU opcode encodings, FSM state
// encoding, shift-kind enumeration and the opcode-to-shift-kind decoder.
package tiny45_pkg;

    localparam int DATA_W  = 32;
    localparam int NIB_W   = 4;
    localparam int NIB_CNT = DATA_W / NIB_W;

    // ALU-format opcodes handled by the shifter
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b1101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_t;

    // Opcode bit 2 selects direction, bit 3 selects sign fill on right shifts.
    // Only bits [3:2] are passed in; bit 0 (enable) is handled by the caller.
    function automatic shift_kind_t decode_kind(input logic [1:0] op_hi);
        shift_kind_t kind;
        if (!op_hi[0]) begin
            kind = SH_SLL;
        end else if (!op_hi[1]) begin
            kind = SH_SRL;
        end else begin
            kind = SH_SRA;
        end
        return kind;
    endfunction

endpackage

// File: rtl/tiny45_barrel_shift.sv
// Purely combinational 32-bit logarithmic barrel shifter: five stages, each
// conditionally shifting by 1, 2, 4, 8 or 16 according to one amount bit.
module tiny45_barrel_shift
    import tiny45_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [4:0]        amt,
    input  shift_kind_t       kind,
    output logic [DATA_W-1:0] result
);

    logic [5:0][DATA_W-1:0] stage;
    logic                   fill;

    // Vacated bits on a right shift take the sign only for arithmetic shifts
    assign fill     = (kind == SH_SRA) ? data[DATA_W-1] : 1'b0;
    assign stage[0] = data;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            logic [DATA_W-1:0] moved;

            // Stage gi shifts by 2**gi when amount bit gi is set
            always_comb begin
                if (kind == SH_SLL) begin
                    moved = {stage[gi][DATA_W-1-SH:0], {SH{1'b0}}};
                end else begin
                    moved = {{SH{fill}}, stage[gi][DATA_W-1:SH]};
                end
            end

            assign stage[gi+1] = amt[gi] ? moved : stage[gi];
        end
    endgenerate

    assign result = stage[5];

endmodule

// File: rtl/tiny45_shifter.sv
// Nibble-serial shifter: captures an operation on start, then streams the
// 32-bit shift result out as eight 4-bit nibbles, least significant first.
// A start on the last unstalled nibble chains the next operation seamlessly.
module tiny45_shifter
    import tiny45_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic        stall,
    output logic [3:0]  d,
    output logic        d_valid,
    output logic        busy,
    output logic        done
);

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic [3:0]         op_reg, op_next;
    logic [DATA_W-1:0]  a_reg, a_next;
    logic [4:0]         b_reg, b_next;

    logic               last_beat;
    logic               accept;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  result;
    logic [NIB_CNT-1:0][NIB_W-1:0] nibbles;

    // Opcode bit 1 carries no meaning for the shifter
    logic               unused_op_bit;
    assign unused_op_bit = op_reg[1];

    // The final nibble is retired only when it is not being held by stall
    assign last_beat = (state_reg == ST_SHIFT) && (cnt_reg == 3'd7) && !stall;
    assign accept    = start && ((state_reg == ST_IDLE) || last_beat);

    tiny45_barrel_shift u_barrel (
        .data   (a_reg),
        .amt    (b_reg),
        .kind   (decode_kind(op_reg[3:2])),
        .result (shifted)
    );

    // Opcodes with bit 0 clear stream zeros but keep normal timing
    assign result = op_reg[0] ? shifted : '0;

    generate
        for (genvar gi = 0; gi < NIB_CNT; gi++) begin : g_nib
            assign nibbles[gi] = result[gi*NIB_W +: NIB_W];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: leave SHIFT only on a retired final nibble without a new start
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start)                 state_next = ST_SHIFT;
            ST_SHIFT: if (last_beat && !start)   state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // Capture operands on an accepted start; otherwise advance on unstalled beats
    always_comb begin
        cnt_next = cnt_reg;
        op_next  = op_reg;
        a_next   = a_reg;
        b_next   = b_reg;
        if (accept) begin
            cnt_next = 3'd0;
            op_next  = op;
            a_next   = a;
            b_next   = b;
        end else if ((state_reg == ST_SHIFT) && !stall) begin
            // Wraps 7 -> 0 on the way back to IDLE
            cnt_next = cnt_reg + 3'd1;
        end
    end

    // Counter and captured-operand registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= 3'd0;
            op_reg  <= 4'd0;
            a_reg   <= '0;
            b_reg   <= 5'd0;
        end else begin
            cnt_reg <= cnt_next;
            op_reg  <= op_next;
            a_reg   <= a_next;
            b_reg   <= b_next;
        end
    end

    // Outputs: everything is quiet in IDLE; SHIFT presents the indexed nibble
    always_comb begin
        d       = 4'd0;
        d_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        if (state_reg == ST_SHIFT) begin
            d       = nibbles[cnt_reg];
            d_valid = 1'b1;
            busy    = 1'b1;
            done    = (cnt_reg == 3'd7) && !stall;
        end
    end

endmodule

// File: doc/tiny45_shifter.md
TINY45_SHIFTER -- requirements
Module: tiny45_shifter

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32-bit operands and 4-bit result nibbles.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a new shift; sampled only when idle or on the final nibble cycle.
REQ-005 op  input  4  ALU-format opcode: 0001 SLL, 0101 SRL, 1101 SRA.
REQ-006 a  input  32  operand to shift; captured on an accepted start.
REQ-007 b  input  5  shift amount; captured on an accepted start.
REQ-008 stall  input  1  holds the current nibble and counter for this cycle.
REQ-009 d  output  4  result nibble, least significant first.
REQ-010 d_valid  output  1  d carries a result nibble this cycle.
REQ-011 busy  output  1  operation in progress; high in IDLE never, high in SHIFT always.
REQ-012 done  output  1  one-cycle pulse with the 8th nibble (nibble index 7) when not stalled.

Function
REQ-013 Two states SHALL exist: IDLE and SHIFT; a 3-bit nibble counter SHALL index the output nibble.
REQ-014 IDLE + start -> capture op, a, b; counter := 0; go to SHIFT; first nibble valid the following cycle (latency 1).
REQ-015 In SHIFT, d SHALL equal bits [4*counter+3 : 4*counter] of the full 32-bit shift of the captured a by captured b.
REQ-016 Shift type from captured op: op[2]=0 -> logical left; op[2]=1, op[3]=0 -> logical right; op[2]=1, op[3]=1 -> arithmetic right (sign fill from a[31]).
REQ-017 Captured op with op[0]=0 SHALL produce eight all-zero nibbles with normal handshake timing.
REQ-018 b=0 SHALL return a unchanged; b=31 SHALL be the maximum shift; no other amounts exist.
REQ-019 d_valid SHALL be high in every SHIFT cycle, including stalled cycles, in which d is unchanged.
REQ-020 Counter SHALL advance by 1 per non-stalled SHIFT cycle; stall has no effect in IDLE.
REQ-021 Non-stalled SHIFT cycle with counter=7: done=1; if start=1, capture new operands, counter := 0, remain in SHIFT (back-to-back, no bubble); else go to IDLE.
REQ-022 start while in SHIFT with counter<7, or with counter=7 and stall=1, SHALL be ignored; captured operands never change mid-operation.
REQ-023 In IDLE: d=0, d_valid=0, busy=0, done=0.
REQ-024 Input changes to a, b, op after capture SHALL NOT affect remaining nibbles.

Reset
REQ-025 rstn low SHALL immediately force IDLE, counter=0, captured a/b/op=0, and d=0, d_valid=0, busy=0, done=0, including mid-operation; the aborted result is discarded.
REQ-026 After rstn rises, the first start SHALL be accepted on the first clock edge it is sampled high.

Structure
REQ-027 Opcode constants (SLL/SRL/SRA encodings) and the state encoding SHALL reside in a shared tiny45 package used alongside the ALU opcode definitions.
REQ-028 A purely combinational 32-bit barrel shift sub-module, tiny45_barrel_shift, SHALL be used; state, counter and nibble selection stay in the top.

Verification
REQ-029 SLL, a=0x00000001, b=4 -> nibbles 0,1,0,0,0,0,0,0 on consecutive cycles, done with the 8th.
REQ-030 SRA a=0x80000000 b=31 -> eight nibbles 0xF; SRL same operands -> 1,0,0,0,0,0,0,0.
REQ-031 SRL a=0x12345678 b=0 with stall high on nibble index 3 for 2 cycles -> 8,7,6,5,5,5,4,3,2,1; done once.
REQ-032 Back-to-back: start held through nibble 7 with new SLL a=0xFFFFFFFF b=28 -> next cycle begins 0,0,0,0,0,0,0,F with no idle cycle.
REQ-033 rstn pulsed low at nibble index 4 -> outputs zero asynchronously; no done pulse; a subsequent start produces a complete correct result.
REQ-034 op=0000 captured -> eight zero nibbles with d_valid high and done on the 8th.
